// File: rtl/reg_bus_master_if.sv
`default_nettype none
// ============================================================================
// reg_bus_master_if : host command/response and register-bus signal bundle
// Revision: 1.0
// ============================================================================
interface reg_bus_master_if #(
  parameter int W_WIDTH = 8
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_wr;
  logic [W_WIDTH-1:0] cmd_addr;
  logic [W_WIDTH-1:0] cmd_wdata;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [W_WIDTH-1:0] rsp_rdata;
  logic               rsp_err;
  logic               sel_en;
  logic               wr_rd_s;
  logic [W_WIDTH-1:0] addr;
  logic [W_WIDTH-1:0] wr_data;
  logic [W_WIDTH-1:0] rd_data;
  logic               ack;
  logic [W_WIDTH-1:0] err_cnt;

  modport master (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rsp_ready, rd_data, ack,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, sel_en, wr_rd_s, addr,
           wr_data, err_cnt
  );

  modport slave (
    output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rsp_ready, rd_data, ack,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, sel_en, wr_rd_s, addr,
           wr_data, err_cnt
  );
endinterface
`default_nettype wire

// File: rtl/reg_bus_master.sv
`default_nettype none
// ============================================================================
// reg_bus_master : single-outstanding register bus master with ack timeout
// Revision: 1.0
// ============================================================================
module reg_bus_master #(
  parameter int W_WIDTH = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  reg_bus_master_if.master bus
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]      c_LAST    = CW'(TIMEOUT - 1);
  localparam logic [W_WIDTH-1:0] c_ERR_MAX = '1;

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_ACCESS = 2'd1;
  localparam logic [1:0] c_RESP   = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_next;
  logic [CW-1:0]      r_cnt;
  logic               r_wr;
  logic [W_WIDTH-1:0] r_addr;
  logic [W_WIDTH-1:0] r_wdata;
  logic [W_WIDTH-1:0] r_rdata;
  logic               r_err;
  logic [W_WIDTH-1:0] r_err_cnt;
  logic               w_timeout;

  assign w_timeout = (r_cnt == c_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:   if (bus.cmd_valid)             w_next = c_ACCESS;
      c_ACCESS: if (bus.ack || w_timeout)      w_next = c_RESP;
      c_RESP:   if (bus.rsp_ready)             w_next = c_IDLE;
      default:                                 w_next = c_IDLE;
    endcase
  end

  // Handshake outputs depend on state only; rst merely masks cmd_ready.
  always_comb begin
    bus.cmd_ready = 1'b0;
    bus.sel_en    = 1'b0;
    bus.rsp_valid = 1'b0;
    case (r_state)
      c_IDLE:   bus.cmd_ready = ~rst;
      c_ACCESS: bus.sel_en    = 1'b1;
      c_RESP:   bus.rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_wr      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (bus.cmd_valid) begin
            r_wr    <= bus.cmd_wr;
            r_addr  <= bus.cmd_addr;
            r_wdata <= bus.cmd_wdata;
            r_cnt   <= '0;
          end
        end
        c_ACCESS: begin
          r_cnt <= r_cnt + 1'b1;
          // ack in the last allowed cycle still counts as success
          if (bus.ack) begin
            r_rdata <= r_wr ? '0 : bus.rd_data;
            r_err   <= 1'b0;
          end else if (w_timeout) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
            if (r_err_cnt != c_ERR_MAX) begin
              r_err_cnt <= r_err_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.wr_rd_s   = r_wr;
  assign bus.addr      = r_addr;
  assign bus.wr_data   = r_wdata;
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;
  assign bus.err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_reg_bus_master.sv
`default_nettype none
// ============================================================================
// tb_reg_bus_master : directed and random checks against a transaction model
// Revision: 1.0
// ============================================================================
module tb_reg_bus_master;

  localparam int W_WIDTH = 8;
  localparam int TIMEOUT = 16;

  logic clk;
  logic rst;
  int   n_err;
  int   n_checks;
  int   model_err;

  reg_bus_master_if #(.W_WIDTH(W_WIDTH)) bus ();

  reg_bus_master #(.W_WIDTH(W_WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // k = index of the sel_en cycle (0-based) on which the slave acks; k<0 means never.
  task automatic access(input bit wr, input logic [7:0] a, input logic [7:0] d,
                        input int k, input logic [7:0] rdv, input int hold);
    int         sel_cycles;
    int         exp_cycles;
    bit         to;
    logic [7:0] exp_rd;
    to = (k < 0) || (k >= TIMEOUT);
    if (to) begin
      exp_cycles = TIMEOUT;
      exp_rd     = 8'h00;
      if (model_err < 255) model_err++;
    end else begin
      exp_cycles = k + 1;
      exp_rd     = wr ? 8'h00 : rdv;
    end
    chk("cmd_ready_idle", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_wr    = wr;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_wr    = ~wr;
    bus.cmd_addr  = 8'($urandom);
    bus.cmd_wdata = 8'($urandom);
    sel_cycles = 0;
    for (int i = 0; i < TIMEOUT + 4 && bus.sel_en === 1'b1; i++) begin
      sel_cycles++;
      chk("bus_dir", bus.wr_rd_s, wr);
      chk("bus_addr", bus.addr, a);
      chk("bus_wdata", bus.wr_data, d);
      chk("cmd_ready_access", bus.cmd_ready, 0);
      bus.ack     = (sel_cycles == k + 1);
      bus.rd_data = bus.ack ? rdv : 8'($urandom);
      @(negedge clk);
      bus.ack = 1'b0;
    end
    chk("sel_cycles", sel_cycles, exp_cycles);
    chk("sel_en_resp", bus.sel_en, 0);
    chk("rsp_valid", bus.rsp_valid, 1);
    chk("rsp_err", bus.rsp_err, to);
    chk("rsp_rdata", bus.rsp_rdata, exp_rd);
    chk("err_cnt", bus.err_cnt, model_err);
    chk("addr_held", bus.addr, a);
    for (int i = 0; i < hold; i++) begin
      bus.rsp_ready = 1'b0;
      bus.ack       = (i == 0);
      bus.rd_data   = 8'($urandom);
      @(negedge clk);
      bus.ack = 1'b0;
      chk("bp_rsp_valid", bus.rsp_valid, 1);
      chk("bp_rsp_rdata", bus.rsp_rdata, exp_rd);
      chk("bp_rsp_err", bus.rsp_err, to);
      chk("bp_cmd_ready", bus.cmd_ready, 0);
      chk("bp_sel_en", bus.sel_en, 0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("rsp_done_valid", bus.rsp_valid, 0);
    chk("rsp_done_cmd_ready", bus.cmd_ready, 1);
    chk("rsp_done_sel_en", bus.sel_en, 0);
  endtask

  initial begin
    bit         t_wr;
    logic [7:0] t_a;
    logic [7:0] t_d;
    logic [7:0] t_r;
    int         t_k;
    int         t_h;

    n_err         = 0;
    n_checks      = 0;
    model_err     = 0;
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_wr    = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    bus.rd_data   = '0;
    bus.ack       = 1'b0;

    // Reset values, including cmd_ready masked while rst is high
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    chk("rst_sel_en", bus.sel_en, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_wr_rd_s", bus.wr_rd_s, 0);
    chk("rst_addr", bus.addr, 0);
    chk("rst_wr_data", bus.wr_data, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_err_cnt", bus.err_cnt, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", bus.cmd_ready, 1);

    // Stray ack in IDLE
    bus.ack     = 1'b1;
    bus.rd_data = 8'h3C;
    @(negedge clk);
    bus.ack = 1'b0;
    chk("stray_idle_sel_en", bus.sel_en, 0);
    chk("stray_idle_rsp_valid", bus.rsp_valid, 0);
    chk("stray_idle_cmd_ready", bus.cmd_ready, 1);

    access(1'b1, 8'h02, 8'hA5, 1, 8'h00, 0);   // write, ack on 2nd cycle
    access(1'b0, 8'h02, 8'h00, 0, 8'hA5, 0);   // read, immediate ack
    access(1'b0, 8'h07, 8'h00, -1, 8'h00, 0);  // timeout, err_cnt 1
    access(1'b0, 8'h07, 8'h00, -1, 8'h00, 0);  // timeout, err_cnt 2
    access(1'b0, 8'h07, 8'h00, TIMEOUT - 1, 8'h5A, 0);  // ack on last cycle wins
    access(1'b0, 8'h11, 8'h00, 2, 8'hC3, 5);   // backpressure with stray ack in RESP

    // Reset on the 3rd ACCESS cycle aborts and clears err_cnt
    chk("mid_cmd_ready", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_wr    = 1'b1;
    bus.cmd_addr  = 8'h33;
    bus.cmd_wdata = 8'h5C;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("mid_sel_c1", bus.sel_en, 1);
    repeat (2) @(negedge clk);
    chk("mid_sel_c3", bus.sel_en, 1);
    rst = 1'b1;
    @(negedge clk);
    model_err = 0;
    chk("mid_sel_en", bus.sel_en, 0);
    chk("mid_rsp_valid", bus.rsp_valid, 0);
    chk("mid_cmd_ready", bus.cmd_ready, 0);
    chk("mid_addr", bus.addr, 0);
    chk("mid_wr_data", bus.wr_data, 0);
    chk("mid_wr_rd_s", bus.wr_rd_s, 0);
    chk("mid_err_cnt", bus.err_cnt, 0);
    chk("mid_rsp_rdata", bus.rsp_rdata, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_after_rsp_valid", bus.rsp_valid, 0);
    access(1'b1, 8'h44, 8'h99, 0, 8'h00, 0);

    // Random transactions
    for (int t = 0; t < 40; t++) begin
      t_wr = 1'($urandom_range(0, 1));
      t_a  = 8'($urandom);
      t_d  = 8'($urandom);
      t_r  = 8'($urandom);
      t_k  = int'($urandom_range(0, TIMEOUT + 2));
      if (t_k >= TIMEOUT) t_k = -1;
      t_h  = int'($urandom_range(0, 3));
      access(t_wr, t_a, t_d, t_k, t_r, t_h);
    end

    // Drive err_cnt into saturation and one step past it
    for (int s = 0; s < 300 && model_err < 255; s++) begin
      access(1'b0, 8'h07, 8'h00, -1, 8'h00, 0);
    end
    access(1'b0, 8'h07, 8'h00, -1, 8'h00, 0);
    chk("err_cnt_saturated", bus.err_cnt, 255);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
